// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC systolic-array sequencer.
// Holds the state encoding, the array instruction codes and the drain watchdog slack.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GAP,
    EXEC,
    DRAIN,
    DONE
  } ctrl_state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam int DRAIN_SLACK = 4;

  // Cycles the watchdog allows beyond cfg_len: worst-case skew through the array plus slack.
  function automatic int drain_extra(input int rows, input int cols);
    return 2 * (rows + cols) + DRAIN_SLACK;
  endfunction

endpackage

// File: rtl/mac_out_addr_gen.sv
// Output-row write counter and psum address generator for mac_array_ctrl.
// Registers the array's last-column valid into a write strobe, capped at cfg_len writes.
module mac_out_addr_gen
  import mac_pkg::*;
#(
  parameter int addr_bw = 11,
  parameter int len_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               capture_en,
  input  logic               abort,
  input  logic               valid_in,
  input  logic [addr_bw-1:0] cfg_o_base,
  input  logic [len_bw-1:0]  len,
  output logic               out_wr_en,
  output logic [addr_bw-1:0] out_wr_addr,
  output logic               complete
);

  logic [addr_bw-1:0] o_base_q, o_base_d;
  logic [len_bw-1:0]  cnt_q, cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [addr_bw-1:0] wr_addr_q, wr_addr_d;

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    o_base_d  = o_base_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    if (clear) begin
      o_base_d = cfg_o_base;
      cnt_d    = '0;
    end else if (capture_en && !abort && valid_in && (cnt_q < len)) begin
      wr_en_d   = 1'b1;
      wr_addr_d = o_base_q + addr_bw'(cnt_q);
      cnt_d     = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_base_q  <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      o_base_q  <= o_base_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign out_wr_en   = wr_en_q;
  assign out_wr_addr = wr_addr_q;
  assign complete    = (cnt_q == len);

endmodule

// File: rtl/mac_array_ctrl.sv
// Tile sequencer for the 2D MAC systolic array: kernel load, pipeline gap, activation
// streaming and drain, with psum write-back, abort and a drain watchdog.
module mac_array_ctrl
  import mac_pkg::*;
#(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int len_bw  = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               cfg_data_mode,
  input  logic [len_bw-1:0]  cfg_len,
  input  logic [addr_bw-1:0] cfg_w_base,
  input  logic [addr_bw-1:0] cfg_x_base,
  input  logic [addr_bw-1:0] cfg_o_base,
  input  logic [col-1:0]     arr_valid,
  output logic               rd_en,
  output logic [addr_bw-1:0] rd_addr,
  output logic [1:0]         inst_w,
  output logic               data_mode,
  output logic               out_wr_en,
  output logic [addr_bw-1:0] out_wr_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int CNT_BW   = (len_bw > $clog2(row) + 1) ? len_bw : $clog2(row) + 1;
  localparam int WD_EXTRA = drain_extra(row, col);
  localparam int WD_BW    = $clog2((2 ** len_bw) + WD_EXTRA + 1);

  ctrl_state_t        state_q, state_d;
  logic [CNT_BW-1:0]  cnt_q, cnt_d;
  logic [WD_BW-1:0]   wd_q, wd_d;
  logic [addr_bw-1:0] w_base_q, w_base_d;
  logic [addr_bw-1:0] x_base_q, x_base_d;
  logic [len_bw-1:0]  len_q, len_d;
  logic               data_mode_q, data_mode_d;
  logic [1:0]         inst_w_q, inst_w_d;
  logic               err_q, err_d;

  logic start_ok;
  logic load_last;
  logic gap_last;
  logic exec_last;
  logic wd_last;
  logic capture_en;
  logic complete;

  // Only the last column's valid marks a finished output row.
  logic unused_arr_valid;
  assign unused_arr_valid = ^arr_valid[col-2:0];

  assign start_ok   = (state_q == IDLE) && start && !abort;
  assign load_last  = (cnt_q == CNT_BW'(row - 1));
  assign gap_last   = data_mode_q || load_last;
  assign exec_last  = (cnt_q == (CNT_BW'(len_q) - CNT_BW'(1)));
  assign wd_last    = (wd_q == (WD_BW'(len_q) + WD_BW'(WD_EXTRA - 1)));
  assign capture_en = (state_q == EXEC) || (state_q == DRAIN);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wd_d        = wd_q;
    w_base_d    = w_base_q;
    x_base_d    = x_base_q;
    len_d       = len_q;
    data_mode_d = data_mode_q;
    inst_w_d    = INST_IDLE;
    err_d       = err_q;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          w_base_d    = cfg_w_base;
          x_base_d    = cfg_x_base;
          len_d       = cfg_len;
          data_mode_d = cfg_data_mode;
          err_d       = 1'b0;
          cnt_d       = '0;
          wd_d        = '0;
          state_d     = (cfg_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        // Instruction follows its read by one cycle to match SRAM latency.
        inst_w_d = INST_LOAD;
        cnt_d    = cnt_q + 1'b1;
        if (load_last) begin
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (gap_last) begin
          cnt_d   = '0;
          wd_d    = '0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        inst_w_d = INST_EXEC;
        cnt_d    = cnt_q + 1'b1;
        wd_d     = wd_q + 1'b1;
        if (exec_last) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        wd_d = wd_q + 1'b1;
        if (complete) begin
          state_d = DONE;
        end else if (wd_last) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort) begin
      state_d  = IDLE;
      inst_w_d = INST_IDLE;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wd_q        <= '0;
      w_base_q    <= '0;
      x_base_q    <= '0;
      len_q       <= '0;
      data_mode_q <= 1'b0;
      inst_w_q    <= INST_IDLE;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wd_q        <= wd_d;
      w_base_q    <= w_base_d;
      x_base_q    <= x_base_d;
      len_q       <= len_d;
      data_mode_q <= data_mode_d;
      inst_w_q    <= inst_w_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state_q == LOAD) begin
      rd_en   = 1'b1;
      rd_addr = w_base_q + addr_bw'(cnt_q);
    end else if (state_q == EXEC) begin
      rd_en   = 1'b1;
      rd_addr = x_base_q + addr_bw'(cnt_q);
    end
  end

  assign inst_w    = inst_w_q;
  assign data_mode = data_mode_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;

  mac_out_addr_gen #(
    .addr_bw(addr_bw),
    .len_bw (len_bw)
  ) u_out_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .capture_en (capture_en),
    .abort      (abort),
    .valid_in   (arr_valid[col-1]),
    .cfg_o_base (cfg_o_base),
    .len        (len_q),
    .out_wr_en  (out_wr_en),
    .out_wr_addr(out_wr_addr),
    .complete   (complete)
  );

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: directed tiles plus randomized tiles, each
// compared cycle by cycle against a timeline computed from the tile-sequencing rules.
module tb_mac_array_ctrl;

  localparam int ROW   = 8;
  localparam int COL   = 8;
  localparam int AW    = 11;
  localparam int LW    = 11;
  localparam int AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_data_mode = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [AW-1:0] cfg_w_base = '0;
  logic [AW-1:0] cfg_x_base = '0;
  logic [AW-1:0] cfg_o_base = '0;
  logic [COL-1:0] arr_valid = '0;

  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [1:0]    inst_w;
  logic          data_mode;
  logic          out_wr_en;
  logic [AW-1:0] out_wr_addr;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  mac_array_ctrl #(.row(ROW), .col(COL), .addr_bw(AW), .len_bw(LW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .cfg_data_mode(cfg_data_mode),
    .cfg_len      (cfg_len),
    .cfg_w_base   (cfg_w_base),
    .cfg_x_base   (cfg_x_base),
    .cfg_o_base   (cfg_o_base),
    .arr_valid    (arr_valid),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .inst_w       (inst_w),
    .data_mode    (data_mode),
    .out_wr_en    (out_wr_en),
    .out_wr_addr  (out_wr_addr),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".rd_en"}, 32'(rd_en), 0);
    chk({tag, ".rd_addr"}, 32'(rd_addr), 0);
    chk({tag, ".inst_w"}, 32'(inst_w), 0);
    chk({tag, ".data_mode"}, 32'(data_mode), 0);
    chk({tag, ".out_wr_en"}, 32'(out_wr_en), 0);
    chk({tag, ".out_wr_addr"}, 32'(out_wr_addr), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".err"}, 32'(err), 0);
  endtask

  // Runs one tile from the current negedge. Cycle c=1 is the first cycle after start is taken.
  // Reference timeline: LOAD at 1..ROW, GAP of ROW (or 1) cycles, EXEC from e for len cycles,
  // instruction one cycle behind each read, array answers each EXEC read d cycles after its
  // instruction, writes one cycle after each valid, done one cycle after the last write or at
  // the watchdog limit counted from EXEC entry.
  task automatic run_tile(input string tag, input int w, input int x, input int o, input int len,
                          input bit dm, input int d, input int nvalid, input bit stray,
                          input int poke_at, input int abort_at);
    int g, e, lim, dc, last_c, n;
    bit err_exp;
    logic          e_rd_en, e_we, e_busy, e_done, e_err;
    logic [AW-1:0] e_rd_addr, e_wa;
    logic [1:0]    e_inst;
    cfg_w_base    = AW'(w);
    cfg_x_base    = AW'(x);
    cfg_o_base    = AW'(o);
    cfg_len       = LW'(len);
    cfg_data_mode = dm;
    start         = 1'b1;
    abort         = 1'b0;
    arr_valid     = '0;
    g   = dm ? 1 : ROW;
    e   = ROW + g + 1;
    lim = len + 2 * (ROW + COL) + 4;
    if (len == 0) begin
      dc = 1; err_exp = 1'b0;
    end else if (nvalid >= len) begin
      dc = e + len + 2 + d; err_exp = 1'b0;
    end else begin
      dc = e + lim; err_exp = 1'b1;
    end
    last_c = (abort_at > 0) ? abort_at + 1 : dc + 1;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      e_rd_en = 1'b0; e_rd_addr = '0; e_inst = 2'b00; e_we = 1'b0; e_wa = '0;
      if (len > 0) begin
        if (c <= ROW) begin
          e_rd_en = 1'b1; e_rd_addr = AW'((w + c - 1) & AMASK);
        end else if (c >= e && c < e + len) begin
          e_rd_en = 1'b1; e_rd_addr = AW'((x + c - e) & AMASK);
        end
        if (c - 1 >= 1 && c - 1 <= ROW) e_inst = 2'b01;
        else if (c - 1 >= e && c - 1 < e + len) e_inst = 2'b10;
        n = c - 2 - e - d;
        if (n >= 0 && n < nvalid && n < len && c - 1 < dc) begin
          e_we = 1'b1; e_wa = AW'((o + n) & AMASK);
        end
      end
      e_busy = (c <= dc);
      e_done = (c == dc);
      e_err  = (c >= dc) ? err_exp : 1'b0;
      if (abort_at > 0 && c > abort_at) begin
        e_rd_en = 1'b0; e_rd_addr = '0; e_inst = 2'b00; e_we = 1'b0;
        e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
      end
      chk({tag, ".rd_en"}, 32'(rd_en), 32'(e_rd_en));
      chk({tag, ".rd_addr"}, 32'(rd_addr), 32'(e_rd_addr));
      chk({tag, ".inst_w"}, 32'(inst_w), 32'(e_inst));
      chk({tag, ".out_wr_en"}, 32'(out_wr_en), 32'(e_we));
      if (e_we) chk({tag, ".out_wr_addr"}, 32'(out_wr_addr), 32'(e_wa));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".done"}, 32'(done), 32'(e_done));
      chk({tag, ".err"}, 32'(err), 32'(e_err));
      chk({tag, ".data_mode"}, 32'(data_mode), 32'(dm));

      start = (c == poke_at);
      if (c == poke_at) begin
        cfg_w_base    = AW'($urandom);
        cfg_x_base    = AW'($urandom);
        cfg_o_base    = AW'($urandom);
        cfg_len       = LW'($urandom_range(0, 30));
        cfg_data_mode = ~dm;
      end
      abort = (c == abort_at);
      arr_valid[COL-2:0] = (COL - 1)'($urandom);
      n = c - e - 1 - d;
      arr_valid[COL-1] = (len > 0 && n >= 0 && n < nvalid) ||
                         (stray && c < e && $urandom_range(0, 1) == 1);
    end
    start     = 1'b0;
    abort     = 1'b0;
    arr_valid = '0;
  endtask

  initial begin
    int len, nv, r;
    bit dm;

    // Reset state while reset is held low.
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    // Test-plan tiles.
    run_tile("tile_dm0", 'h010, 'h100, 'h000, 4, 1'b0, 2, 4, 1'b1, 3, 0);
    run_tile("tile_dm1", 'h010, 'h100, 'h020, 4, 1'b1, 1, 4, 1'b1, 5, 0);
    run_tile("o_wrap", 'h3F0, 'h7FD, 'h7FE, 3, 1'b0, 3, 5, 1'b0, 0, 0);
    run_tile("timeout", 'h040, 'h200, 'h100, 4, 1'b0, 2, 2, 1'b0, 0, 0);
    run_tile("err_clear", 'h050, 'h210, 'h110, 2, 1'b1, 0, 2, 1'b0, 0, 0);
    run_tile("abort_exec", 'h060, 'h220, 'h120, 6, 1'b1, 2, 6, 1'b0, 0, ROW + 1 + 1 + 2);
    run_tile("after_abort", 'h070, 'h230, 'h130, 3, 1'b0, 1, 3, 1'b0, 0, 0);
    run_tile("len_zero", 'h080, 'h240, 'h140, 0, 1'b1, 0, 0, 1'b1, 0, 0);

    // Abort and start in the same cycle: the start is dropped.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start.busy", 32'(busy), 0);
    chk("abort_start.rd_en", 32'(rd_en), 0);
    chk("abort_start.done", 32'(done), 0);

    // Randomized tiles.
    for (int t = 0; t < 14; t++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 24));
      dm  = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 5));
      nv  = (r == 0 && len > 0) ? len - 1 : (r == 1) ? len + 2 : len;
      run_tile("rand", int'($urandom), int'($urandom), int'($urandom), len, dm,
               int'($urandom_range(0, 5)), nv, 1'($urandom_range(0, 1)),
               int'($urandom_range(2, ROW)), 0);
    end

    // Reset asserted mid-LOAD clears outputs immediately.
    cfg_w_base    = AW'('h300);
    cfg_len       = LW'(5);
    cfg_data_mode = 1'b1;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_load.rd_en", 32'(rd_en), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("mid_load_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
